branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Execute-stage branch resolution unit with a parametrised bimodal branch history table (BHT).
- Resolves the branch condition and compares it against the prediction made at fetch. Generates pc_sel and the IF/DEC kill signals only on a misprediction or an unconditional redirect.
- Stretches the fence.i fetch kill over a configurable number of cycles.
- Keeps saturating branch and mispredict statistics counters.
- Sits between the ALU compare outputs, the fetch PC mux and the CSR/exception logic.

Parameters:
XLEN, 32, PC and statistics counter width.
BHT_ENTRIES, 64, number of 2-bit counters; must be a power of 2 and at least 2.
FENCE_KILL_CYCLES, 2, cycles if_kill stays high after fence_i deasserts; range 0..15.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
fetch_pc  input  XLEN  PC being fetched, used for BHT lookup
pred_taken  output  1  combinational prediction for fetch_pc
br_valid  input  1  execute-stage instruction is valid
br_type  input  4  N=0, NE=1, EQ=2, GE=3, GEU=4, LT=5, LTU=6, J=7, JR=8; values 9-15 treated as N
br_eq  input  1  rs1==rs2
br_lt  input  1  rs1<rs2, signed
br_ltu  input  1  rs1<rs2, unsigned
br_pc  input  XLEN  PC of the execute-stage instruction
ex_pred_taken  input  1  prediction carried down the pipe with this instruction
pipeline_kill  input  1  exception/trap redirect
fence_i  input  1  fence.i in execute
stat_clear  input  1  synchronous clear of the statistics counters
pc_sel  output  3  PC_4=0, PC_BRJMP=1, PC_JALR=2, PC_EXC=3, PC_SEQ=4 (redirect to br_pc+4)
pc_sel_q  output  3  pc_sel registered one cycle
if_kill  output  1  kill the fetch stage
dec_kill  output  1  kill the decode stage
mispredict  output  1  conditional branch resolved against its prediction
br_count  output  XLEN  resolved conditional branches
mispred_count  output  XLEN  mispredicted conditional branches

Behaviour:
- Reset (asynchronous, rst_n low): every BHT entry = 2'b01 (weakly not-taken). pc_sel_q=PC_4. Fence counter=0. br_count=0. mispred_count=0.
- Combinational outputs follow inputs immediately. With br_valid=0, fence_i=0 and pipeline_kill=0, the outputs are PC_4 / 0.
- cond = br_valid && br_type in 1..6.
- taken: NE=!br_eq, EQ=br_eq, GE=!br_lt, GEU=!br_ltu, LT=br_lt, LTU=br_ltu.
- BHT index for both lookup and update = PC[log2(BHT_ENTRIES)+1:2]. pred_taken = entry[1] of fetch_pc's entry.
- pc_sel priority, first match wins:
  1. pipeline_kill -> PC_EXC.
  2. br_valid && J -> PC_BRJMP.
  3. br_valid && JR -> PC_JALR.
  4. cond && taken && !ex_pred_taken -> PC_BRJMP.
  5. cond && !taken && ex_pred_taken -> PC_SEQ.
  6. otherwise -> PC_4.
- mispredict = cond && (taken != ex_pred_taken) && !pipeline_kill.
- dec_kill = (pc_sel != PC_4).
- if_kill = (pc_sel != PC_4) || fence_i || (fence_cnt != 0).
- fence_cnt:
  - Loads FENCE_KILL_CYCLES on every cycle fence_i=1; a retrigger reloads it.
  - Otherwise decrements while nonzero.
  - FENCE_KILL_CYCLES=0 gives kill only in cycles where fence_i=1.
- BHT update at posedge when cond && !pipeline_kill: taken -> saturating increment (max 2'b11), else saturating decrement (min 2'b00).
- BHT read-during-write at the same index: pred_taken shows the pre-update value in that cycle and the new value from the next cycle.
- Statistics counters update on the same condition as the BHT:
  - br_count += 1.
  - mispred_count += mispredict.
  - Both saturate at all-ones, with no wrap.
  - stat_clear has priority over an increment in the same cycle; the counters read 0 next cycle.
- pc_sel_q <= pc_sel every cycle.
- Reset asserted mid-operation: all state returns to its reset value immediately. pending fence kill cycles are dropped.
- Killed or invalid instructions (pipeline_kill=1 or br_valid=0) never modify the BHT or the statistics counters.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0. BEQ br_pc=0x100, br_eq=1, ex_pred_taken=0 -> pc_sel=1, if_kill=dec_kill=1, mispredict=1; next cycle entry 2'b10, pred_taken=1, br_count=1, mispred_count=1.
- BNE br_eq=1 with ex_pred_taken=1 -> pc_sel=4, kills=1. BLT br_lt=1 with ex_pred_taken=1 -> pc_sel=0, kills=0, mispredict=0.
- Four taken BGEU at br_pc=0x200 -> entry saturates at 2'b11. Four not-taken -> 2'b00. A fifth not-taken -> stays 2'b00.
- pipeline_kill=1 with taken BEQ and ex_pred_taken=0 -> pc_sel=3, mispredict=0, BHT and counters unchanged. JR -> pc_sel=2. J -> pc_sel=1.
- FENCE_KILL_CYCLES=2, fence_i pulsed for 1 cycle -> if_kill high for 3 cycles, dec_kill 0. Second pulse in the 2nd cycle -> if_kill high for 4 cycles total.
- Force br_count to all-ones via repeated branches (XLEN=8 build) -> holds at 0xFF. stat_clear asserted together with a branch -> both counters 0. rst_n low mid-fence-kill -> if_kill drops to 0 immediately.

Source files
------------

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - execute-stage branch resolution with bimodal BHT, fence.i kill stretch and stats
module branch_predict_unit #(
  parameter int XLEN              = 32,
  parameter int BHT_ENTRIES       = 64,
  parameter int FENCE_KILL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            br_valid,
  input  logic [3:0]      br_type,
  input  logic            br_eq,
  input  logic            br_lt,
  input  logic            br_ltu,
  input  logic [XLEN-1:0] br_pc,
  input  logic            ex_pred_taken,
  input  logic            pipeline_kill,
  input  logic            fence_i,
  input  logic            stat_clear,
  output logic [2:0]      pc_sel,
  output logic [2:0]      pc_sel_q,
  output logic            if_kill,
  output logic            dec_kill,
  output logic            mispredict,
  output logic [XLEN-1:0] br_count,
  output logic [XLEN-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [2:0] PC_4     = 3'd0;
  localparam logic [2:0] PC_BRJMP = 3'd1;
  localparam logic [2:0] PC_JALR  = 3'd2;
  localparam logic [2:0] PC_EXC   = 3'd3;
  localparam logic [2:0] PC_SEQ   = 3'd4;

  localparam logic [3:0] BR_N   = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_EQ  = 4'd2;
  localparam logic [3:0] BR_GE  = 4'd3;
  localparam logic [3:0] BR_GEU = 4'd4;
  localparam logic [3:0] BR_LT  = 4'd5;
  localparam logic [3:0] BR_LTU = 4'd6;
  localparam logic [3:0] BR_J   = 4'd7;
  localparam logic [3:0] BR_JR  = 4'd8;

  localparam logic [3:0] FENCE_LOAD = 4'(FENCE_KILL_CYCLES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;
  logic [3:0]       fence_cnt;
  logic             cond;
  logic             taken;
  logic             update;

  // Word-aligned PC bits select the counter; the rest of the PC is not needed.
  assign lookup_idx = fetch_pc[IDX_W+1:2];
  assign update_idx = br_pc[IDX_W+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                            br_pc[XLEN-1:IDX_W+2], br_pc[1:0]};

  assign pred_taken = bht[lookup_idx][1];

  always_comb begin
    cond  = 1'b0;
    taken = 1'b0;
    if (br_valid) begin
      case (br_type)
        BR_NE:   begin cond = 1'b1; taken = !br_eq;  end
        BR_EQ:   begin cond = 1'b1; taken = br_eq;   end
        BR_GE:   begin cond = 1'b1; taken = !br_lt;  end
        BR_GEU:  begin cond = 1'b1; taken = !br_ltu; end
        BR_LT:   begin cond = 1'b1; taken = br_lt;   end
        BR_LTU:  begin cond = 1'b1; taken = br_ltu;  end
        default: begin cond = 1'b0; taken = 1'b0;    end
      endcase
    end
  end

  always_comb begin
    pc_sel = PC_4;
    if (pipeline_kill)
      pc_sel = PC_EXC;
    else if (br_valid && br_type == BR_J)
      pc_sel = PC_BRJMP;
    else if (br_valid && br_type == BR_JR)
      pc_sel = PC_JALR;
    else if (cond && taken && !ex_pred_taken)
      pc_sel = PC_BRJMP;
    else if (cond && !taken && ex_pred_taken)
      pc_sel = PC_SEQ;
  end

  assign mispredict = cond && (taken != ex_pred_taken) && !pipeline_kill;
  assign dec_kill   = (pc_sel != PC_4);
  assign if_kill    = (pc_sel != PC_4) || fence_i || (fence_cnt != 4'd0);
  assign update     = cond && !pipeline_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (update) begin
      if (taken) begin
        if (bht[update_idx] != 2'b11)
          bht[update_idx] <= bht[update_idx] + 2'd1;
      end else begin
        if (bht[update_idx] != 2'b00)
          bht[update_idx] <= bht[update_idx] - 2'd1;
      end
    end
  end

  // Each fence_i cycle reloads the stretch, so back-to-back pulses extend the kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fence_cnt <= 4'd0;
    else if (fence_i)
      fence_cnt <= FENCE_LOAD;
    else if (fence_cnt != 4'd0)
      fence_cnt <= fence_cnt - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_sel_q <= PC_4;
    else
      pc_sel_q <= pc_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (stat_clear) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (update) begin
      if (br_count != '1)
        br_count <= br_count + 1'b1;
      if (mispredict && mispred_count != '1)
        mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule
